// File: rtl/spart_driver.sv
`timescale 1ns/1ps
// spart_driver: CPU stand-in bus master for the SPART. It programs the baud
// divisor from the board switches, then echoes every received byte back out.
// The state register holds the access currently pending or in flight. Each
// access gets one issue (gap) cycle with iocs=0, followed by one bus cycle
// with iocs=1.
module spart_driver #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] echo_byte,
  output logic [7:0] echo_cnt
);

  localparam int unsigned DIV_4800  = CLK_HZ / (16 * 4800) - 1;
  localparam int unsigned DIV_9600  = CLK_HZ / (16 * 9600) - 1;
  localparam int unsigned DIV_19200 = CLK_HZ / (16 * 19200) - 1;
  localparam int unsigned DIV_38400 = CLK_HZ / (16 * 38400) - 1;

  localparam logic [1:0] ADDR_DATA  = 2'b00;
  localparam logic [1:0] ADDR_STAT  = 2'b01;
  localparam logic [1:0] ADDR_DIVLO = 2'b10;
  localparam logic [1:0] ADDR_DIVHI = 2'b11;

  // Settle time, in cycles, for the br_cfg synchroniser after reset.
  localparam logic [1:0] SYNC_DEPTH = 2'd2;

  typedef enum logic [2:0] {
    PROG_LO,
    PROG_HI,
    POLL,
    RX_RD,
    TX_WAIT,
    TX_WR
  } state_t;

  state_t     state_q, state_n;
  logic [1:0] cfg_meta, cfg_sync;
  logic [1:0] cfg_cur, cfg_cur_n;
  logic [1:0] sync_cnt;
  logic       sync_ready;
  logic       iocs_n, iorw_n;
  logic [1:0] ioaddr_n;
  logic [7:0] wr_data, wr_data_n;
  logic [7:0] echo_byte_n, echo_cnt_n;
  logic [15:0] div_new, div_cur;
  logic       pins_unused;

  // Baud select to divisor mapping.
  function automatic logic [15:0] divisor(input logic [1:0] cfg);
    case (cfg)
      2'b00:   divisor = 16'(DIV_4800);
      2'b01:   divisor = 16'(DIV_9600);
      2'b10:   divisor = 16'(DIV_19200);
      default: divisor = 16'(DIV_38400);
    endcase
  endfunction

  assign div_new = divisor(cfg_sync);
  assign div_cur = divisor(cfg_cur);

  // The rda/tbr pins are debug visibility only; decisions use the status byte.
  assign pins_unused = rda ^ tbr;

  // Drive the shared bus only during our own write cycles.
  assign databus = (iocs && !iorw) ? wr_data : 8'hzz;

  assign sync_ready = (sync_cnt == SYNC_DEPTH);

  // Two-flop synchroniser for the switches. The first divisor write is held
  // off until the synchroniser holds the real switch value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_meta <= 2'b00;
      cfg_sync <= 2'b00;
      sync_cnt <= 2'd0;
    end else begin
      cfg_meta <= br_cfg;
      cfg_sync <= cfg_meta;
      if (!sync_ready) sync_cnt <= sync_cnt + 2'd1;
    end
  end

  // State register and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PROG_LO;
      cfg_cur   <= 2'b00;
      iocs      <= 1'b0;
      iorw      <= 1'b1;
      ioaddr    <= ADDR_DATA;
      wr_data   <= 8'h00;
      echo_byte <= 8'h00;
      echo_cnt  <= 8'h00;
    end else begin
      state_q   <= state_n;
      cfg_cur   <= cfg_cur_n;
      iocs      <= iocs_n;
      iorw      <= iorw_n;
      ioaddr    <= ioaddr_n;
      wr_data   <= wr_data_n;
      echo_byte <= echo_byte_n;
      echo_cnt  <= echo_cnt_n;
    end
  end

  // Next state and outputs. With iocs=1 the bus cycle completes and read data
  // decides the next access. With iocs=0 the pending access is issued.
  always_comb begin
    state_n     = state_q;
    cfg_cur_n   = cfg_cur;
    iocs_n      = 1'b0;
    iorw_n      = 1'b1;
    ioaddr_n    = ADDR_DATA;
    wr_data_n   = 8'h00;
    echo_byte_n = echo_byte;
    echo_cnt_n  = echo_cnt;

    if (iocs) begin
      case (state_q)
        PROG_LO: state_n = PROG_HI;
        PROG_HI: state_n = POLL;
        POLL: begin
          if (cfg_sync != cfg_cur) state_n = PROG_LO;
          else if (databus[0])     state_n = RX_RD;
          else                     state_n = POLL;
        end
        RX_RD: begin
          echo_byte_n = databus;
          state_n     = TX_WAIT;
        end
        // A switch change seen here waits until the echo is written.
        TX_WAIT: begin
          if (databus[1]) state_n = TX_WR;
          else            state_n = TX_WAIT;
        end
        TX_WR: begin
          echo_cnt_n = echo_cnt + 8'd1;
          state_n    = POLL;
        end
        default: state_n = PROG_LO;
      endcase
    end else if (sync_ready) begin
      iocs_n = 1'b1;
      case (state_q)
        PROG_LO: begin
          cfg_cur_n = cfg_sync;
          iorw_n    = 1'b0;
          ioaddr_n  = ADDR_DIVLO;
          wr_data_n = div_new[7:0];
        end
        PROG_HI: begin
          iorw_n    = 1'b0;
          ioaddr_n  = ADDR_DIVHI;
          wr_data_n = div_cur[15:8];
        end
        POLL, TX_WAIT: ioaddr_n = ADDR_STAT;
        RX_RD:         ioaddr_n = ADDR_DATA;
        TX_WR: begin
          iorw_n    = 1'b0;
          ioaddr_n  = ADDR_DATA;
          wr_data_n = echo_byte;
        end
        default: iocs_n = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
`timescale 1ns/1ps
// tb_spart_driver: randomized echo traffic against a behavioural SPART model,
// with a write scoreboard and a per-cycle bus monitor.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  wire        rda, tbr;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [7:0] echo_byte, echo_cnt;

  spart_driver #(.CLK_HZ(50000000)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .echo_byte(echo_byte), .echo_cnt(echo_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Divisor straight from the baud rate: 4800 doubled per select step.
  function automatic logic [15:0] ref_div(input logic [1:0] cfg);
    int unsigned baud;
    baud = 32'd4800 << cfg;
    return 16'(32'd50000000 / (32'd16 * baud) - 32'd1);
  endfunction

  // SPART model: rx byte stream plus a busy count for tbr.
  logic [7:0] rx_mem [1024];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         tbr_wait = 0;
  int         tbr_delay = 0;
  logic [7:0] idle_pat = 8'h00;
  logic [7:0] tb_drv;
  logic       rda_m, tbr_m;

  assign rda_m = (rx_wr != rx_rd);
  assign tbr_m = (tbr_wait == 0);
  assign rda   = rda_m;
  assign tbr   = tbr_m;

  always_comb begin
    tb_drv = idle_pat;
    if (iocs && iorw) begin
      if (ioaddr == 2'b01)      tb_drv = {6'b0, tbr_m, rda_m};
      else if (ioaddr == 2'b00) tb_drv = rx_mem[rx_rd[9:0]];
      else                      tb_drv = 8'hEE;
    end
  end

  // Outside our own read cycles the bench still drives a random pattern, so a
  // driver that fails to release the bus corrupts what is seen on it.
  assign databus = (iocs && !iorw) ? 8'hzz : tb_drv;

  // SPART side effects of completed reads.
  always @(posedge clk) begin
    idle_pat <= 8'($urandom);
    if (!rst && iocs && iorw) begin
      if (ioaddr == 2'b00 && rda_m) begin
        rx_rd    <= rx_rd + 1;
        tbr_wait <= tbr_delay;
      end else if (ioaddr == 2'b01 && tbr_wait > 0) begin
        tbr_wait <= tbr_wait - 1;
      end
    end
  end

  // Expected write cycles, in order.
  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int         cyc = 0;
  int         last_acc = 0;
  bit         first_acc = 1'b1;
  int         model_cnt = 0;
  bit         pend_eb = 1'b0;
  logic [7:0] pend_val = 8'h00;
  logic [7:0] last_status = 8'h00;
  int         stat_since_rx = 0;
  int         exp_stat_reads = 0;
  wr_t        mon_e;

  // Monitor: protocol checks every cycle, scoreboard pop on every write.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      first_acc = 1'b1;
      model_cnt = 0;
      pend_eb   = 1'b0;
    end else begin
      if (pend_eb) begin
        check("echo_byte", 32'(echo_byte), 32'(pend_val));
        pend_eb = 1'b0;
      end
      if (!(iocs && !iorw)) check("bus_release", 32'(databus), 32'(tb_drv));
      if (!iocs) check("idle_iorw", 32'(iorw), 32'd1);
      if (iocs) begin
        if (first_acc) check("first_access", 32'({iorw, ioaddr}), 32'({1'b0, 2'b10}));
        else           check("access_gap", 32'(cyc - last_acc), 32'd2);
        first_acc = 1'b0;
        last_acc  = cyc;
        if (iorw) begin
          if (ioaddr == 2'b01) begin
            last_status = tb_drv;
            stat_since_rx++;
          end else begin
            check("rx_read_addr", 32'(ioaddr), 32'd0);
            check("rx_read_has_data", 32'(rda_m), 32'd1);
            pend_eb        = 1'b1;
            pend_val       = tb_drv;
            stat_since_rx  = 0;
            exp_stat_reads = tbr_delay + 1;
          end
        end else begin
          check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(ioaddr), 32'(mon_e.addr));
            check("wr_data", 32'(databus), 32'(mon_e.data));
          end
          if (ioaddr == 2'b00) begin
            check("tx_after_tbr", 32'(last_status[1]), 32'd1);
            check("tbr_polls", 32'(stat_since_rx), 32'(exp_stat_reads));
            check("cnt_before_wr", 32'(echo_cnt), 32'(model_cnt[7:0]));
            model_cnt++;
          end
        end
      end
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[9:0]] = b;
    exp_q.push_back(wr_t'{addr: 2'b00, data: b});
    rx_wr = rx_wr + 1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || rx_wr != rx_rd) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] cfg);
    logic [15:0] d;
    @(negedge clk);
    rst    = 1'b1;
    br_cfg = cfg;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_iocs", 32'(iocs), 32'd0);
    check("rst_iorw", 32'(iorw), 32'd1);
    check("rst_ioaddr", 32'(ioaddr), 32'd0);
    check("rst_echo_byte", 32'(echo_byte), 32'd0);
    check("rst_echo_cnt", 32'(echo_cnt), 32'd0);
    check("rst_bus", 32'(databus), 32'(tb_drv));
    d = ref_div(cfg);
    exp_q.push_back(wr_t'{addr: 2'b10, data: d[7:0]});
    exp_q.push_back(wr_t'{addr: 2'b11, data: d[15:8]});
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int nb;

    // Reset, program 9600, then idle status polling.
    do_reset(2'b01);
    repeat (30) @(negedge clk);
    check("prog_done", 32'(exp_q.size()), 32'd0);

    // Single echo with the transmitter ready.
    tbr_delay = 0;
    push_rx(8'h5A);
    wait_drain("drain_single", 200);
    check("echo_cnt_1", 32'(echo_cnt), 32'd1);
    check("echo_byte_5a", 32'(echo_byte), 32'h5A);

    // Transmitter busy for 10 status reads.
    tbr_delay = 10;
    push_rx(8'hA7);
    wait_drain("drain_busy", 300);
    check("echo_cnt_2", 32'(echo_cnt), 32'd2);
    tbr_delay = 0;

    // Switch change while idle: reprogram to 38400.
    @(negedge clk);
    br_cfg = 2'b11;
    exp_q.push_back(wr_t'{addr: 2'b10, data: 8'h50});
    exp_q.push_back(wr_t'{addr: 2'b11, data: 8'h00});
    k = 0;
    while (k < 8) begin
      @(negedge clk);
      k++;
      if (iocs && !iorw && ioaddr == 2'b10) break;
    end
    check("reprog_latency_le5", 32'(k <= 5), 32'd1);
    wait_drain("drain_reprog", 100);

    // Random echo bursts with random transmitter busy time.
    for (int i = 0; i < 12; i++) begin
      tbr_delay = int'($urandom_range(0, 3));
      nb = int'($urandom_range(1, 3));
      for (int j = 0; j < nb; j++) push_rx(8'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      wait_drain("drain_random", 400);
    end

    // Reset asserted in the middle of a tx write.
    tbr_delay = 0;
    push_rx(8'hC6);
    k = 0;
    while (k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (iocs && !iorw && ioaddr == 2'b00) break;
    end
    check("saw_tx_wr", 32'(k < 200), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_iocs", 32'(iocs), 32'd0);
    check("midrst_bus", 32'(databus), 32'(tb_drv));
    check("midrst_cnt", 32'(echo_cnt), 32'd0);
    do_reset(2'b11);
    wait_drain("drain_after_rst", 100);

    // 256 back-to-back echoes: counter wraps.
    for (int j = 0; j < 256; j++) push_rx(8'($urandom));
    wait_drain("drain_256", 4000);
    check("echo_total", 32'(model_cnt), 32'd256);
    check("echo_cnt_wrap", 32'(echo_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
